toffoli_gate_reg: RTL and testbench
===================================

// Module: toffoli_gate_reg
// PURPOSE
// - Registered, bit-parallel reversible Toffoli (CCNOT) gate over WIDTH-bit words.
// - Per bit i: P[i]=A[i], Q[i]=B[i], R[i]=C[i]^(A[i]&B[i]).
// - Primitive for the reversible-logic ALU datapath: AND (C=0), NAND (C=1) and
//   copy/fan-out functions are built from it.
// - Outputs are registered so the gate can be chained stage by stage.
// PARAMETERS
// - WIDTH        32  bit width of every data port
// - PIPE_STAGES  1   register stages between inputs and outputs; legal range 1..4
// PORTS
// - clk  input   1      system clock; all state changes on its rising edge
// - rst  input   1      reset; synchronous and active-high
// - A    input   WIDTH  control input 1
// - B    input   WIDTH  control input 2
// - C    input   WIDTH  target input
// - P    output  WIDTH  pass-through of A
// - Q    output  WIDTH  pass-through of B
// - R    output  WIDTH  target output, C ^ (A & B)
// BEHAVIOUR
// - Reset:
//   - Synchronous, active-high, one clock, single clock domain.
//   - While rst is high at a rising edge, every pipeline register is cleared to 0,
//     so P=Q=R=0 at the next edge.
//   - rst has priority over data capture.
// - Latency:
//   - Inputs are sampled on the rising edge.
//   - Results appear on P/Q/R exactly PIPE_STAGES edges later.
//   - Throughput is one new word per cycle; there is no handshake and no stall.
//   - Outputs hold their value while inputs are unchanged.
// - Function:
//   - Bitwise logic only, with no carries between bits, so no overflow or width growth.
//   - All three outputs are computed from the same sampled input triple; never mix
//     inputs from different edges.
// - Reversibility:
//   - Feeding (P,Q,R) back into A,B,C reproduces the original (A,B,C) after a
//     further PIPE_STAGES cycles.
// - Reset mid-stream:
//   - All in-flight words are discarded.
//   - After rst deasserts, outputs stay 0 until the first post-reset input has
//     propagated PIPE_STAGES stages.
// - Power-up before the first reset: output values are don't-care; no X may
//   propagate past the first reset.
// - Inputs changing between edges have no effect; there is no combinational path
//   from input to output.
// STRUCTURE
// - Sub-module toffoli_cell: one-bit combinational CCNOT (a,b,c -> p,q,r).
//   Instantiate WIDTH copies with a generate loop.
// - A generate-built register pipeline of PIPE_STAGES stages, with a 3*WIDTH-bit
//   payload per stage, follows the cells.
// - Shared package reversible_pkg:
//   - DATA_W = 32 default width constant.
//   - A typedef for a WIDTH-bit data word.
//   - A helper function toffoli_ref(a,b,c) returning {a,b,c^(a&b)}, used by the RTL
//     and by benches as the golden model.
// TESTING
// - Stimulus is applied away from the clock edge. Outputs are checked PIPE_STAGES
//   edges after capture, with PIPE_STAGES=1.
// - Reset: rst=1 for 2 edges with A=B=C=FFFFFFFF -> P=Q=R=00000000; after deassert,
//   the next edge gives P=Q=FFFFFFFF, R=00000000.
// - A=AAAAAAAA, B=55555555, C=00000000 -> P=AAAAAAAA, Q=55555555, R=00000000.
// - A=B=C=FFFFFFFF -> P=Q=FFFFFFFF, R=00000000.
// - A=12345678, B=87654321, C=ABCDEF01 -> P=12345678, Q=87654321, R=A9E9AD21.
// - A=0F0F0F0F, B=F0F0F0F0, C=00FF00FF -> R=00FF00FF, and P/Q pass through unchanged.
// - Reversibility: feed each output triple back as the next input -> the original
//   triple returns. Run 1000 random back-to-back words against toffoli_ref, with a
//   reset mid-stream -> zeros, then a clean restart.

Source files
------------

// File: rtl/reversible_pkg.sv
// Shared definitions for the reversible-logic datapath: default width,
// data word type and the golden Toffoli reference function.
package reversible_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;

    // Golden CCNOT over a whole word: returns {p, q, r} = {a, b, c ^ (a & b)}.
    function automatic logic [3*DATA_W-1:0] toffoli_ref(
        input data_t a,
        input data_t b,
        input data_t c
    );
        return {a, b, c ^ (a & b)};
    endfunction

endpackage

// File: rtl/toffoli_cell.sv
// One-bit combinational Toffoli (CCNOT) cell: controls pass through,
// target flips when both controls are set.
module toffoli_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic p,
    output logic q,
    output logic r
);

    assign p = a;
    assign q = b;
    assign r = c ^ (a & b);

endmodule

// File: rtl/toffoli_gate_reg.sv
// Registered bit-parallel Toffoli gate. WIDTH independent cells feed a
// PIPE_STAGES-deep register pipeline carrying the {P,Q,R} triple together,
// so all three outputs always come from the same sampled input edge.
// PIPE_STAGES is intended to be 1..4.
module toffoli_gate_reg
    import reversible_pkg::*;
#(
    parameter int WIDTH       = DATA_W,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
);

    localparam int PAYLOAD_W = 3 * WIDTH;

    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] r_s;

    // chain_s[0] is the combinational cell result; chain_s[k] is the
    // output of register stage k.
    logic [PIPE_STAGES:0][PAYLOAD_W-1:0] chain_s;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gen_cell
            toffoli_cell u_cell (
                .a (A[gi]),
                .b (B[gi]),
                .c (C[gi]),
                .p (p_s[gi]),
                .q (q_s[gi]),
                .r (r_s[gi])
            );
        end
    endgenerate

    assign chain_s[0] = {p_s, q_s, r_s};

    genvar gs;
    generate
        for (gs = 0; gs < PIPE_STAGES; gs++) begin : gen_stage
            logic [PAYLOAD_W-1:0] data_r;

            // Pipeline stage register; reset discards any in-flight word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_r <= {PAYLOAD_W{1'b0}};
                end else begin
                    data_r <= chain_s[gs];
                end
            end

            assign chain_s[gs+1] = data_r;
        end
    endgenerate

    assign {P, Q, R} = chain_s[PIPE_STAGES];

endmodule

// File: tb/tb_toffoli_gate_reg.sv
// Self-checking bench for toffoli_gate_reg: directed vectors, reset,
// reversibility round-trips and a long random stream with a mid-stream reset.
module tb_toffoli_gate_reg;

    localparam int W   = 32;
    localparam int LAT = 1;

    logic         clk;
    logic         rst;
    logic [W-1:0] A, B, C;
    logic [W-1:0] P, Q, R;

    int checks = 0;
    int errors = 0;

    // Expected output triple per pipeline position, modelled as a plain delay line.
    logic [3*W-1:0] mdl [LAT];

    toffoli_gate_reg #(.WIDTH(W), .PIPE_STAGES(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .P   (P),
        .Q   (Q),
        .R   (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Apply one input word (from a negedge), clock it in, update the model,
    // optionally wiggle inputs between edges, and return at the next negedge.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic r_in, input bit glitch);
        A = a; B = b; C = c; rst = r_in;
        @(posedge clk);
        if (r_in) begin
            for (int i = 0; i < LAT; i++) mdl[i] = '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0] = {a, b, c ^ (a & b)};
        end
        if (glitch) begin
            #2;
            A = $urandom; B = $urandom; C = $urandom;
        end
        @(negedge clk);
    endtask

    task automatic check_out(input string tag);
        check({tag, ".P"}, P, mdl[LAT-1][3*W-1:2*W]);
        check({tag, ".Q"}, Q, mdl[LAT-1][2*W-1:W]);
        check({tag, ".R"}, R, mdl[LAT-1][W-1:0]);
    endtask

    logic [W-1:0] xa, xb, xc, ya, yb, yc;

    initial begin
        rst = 1'b1;
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; C = 32'hFFFF_FFFF;
        for (int i = 0; i < LAT; i++) mdl[i] = '0;
        @(negedge clk);

        // Reset held for two edges with all-ones inputs.
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("rst1.P", P, 32'h0000_0000);
        check("rst1.Q", Q, 32'h0000_0000);
        check("rst1.R", R, 32'h0000_0000);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("rst2.P", P, 32'h0000_0000);
        check("rst2.Q", Q, 32'h0000_0000);
        check("rst2.R", R, 32'h0000_0000);

        // First word after reset release.
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("post_rst.P", P, 32'hFFFF_FFFF);
        check("post_rst.Q", Q, 32'hFFFF_FFFF);
        check("post_rst.R", R, 32'h0000_0000);

        // Directed vectors with hand-computed results.
        step(32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b0);
        check("alt.P", P, 32'hAAAA_AAAA);
        check("alt.Q", Q, 32'h5555_5555);
        check("alt.R", R, 32'h0000_0000);
        step(32'h1234_5678, 32'h8765_4321, 32'hABCD_EF01, 1'b0, 1'b1);
        check("mix.P", P, 32'h1234_5678);
        check("mix.Q", Q, 32'h8765_4321);
        check("mix.R", R, 32'hA9E9_AD21);
        step(32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h00FF_00FF, 1'b0, 1'b0);
        check("nib.P", P, 32'h0F0F_0F0F);
        check("nib.Q", Q, 32'hF0F0_F0F0);
        check("nib.R", R, 32'h00FF_00FF);
        // Same inputs again: outputs hold.
        step(32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h00FF_00FF, 1'b0, 1'b0);
        check("hold.R", R, 32'h00FF_00FF);
        // AND and NAND usage.
        step(32'hF0F0_1234, 32'hFF00_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        check("and.R", R, 32'hF000_1234);
        step(32'hF0F0_1234, 32'hFF00_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("nand.R", R, 32'h0FFF_EDCB);

        // Reversibility: feed observed outputs back, original triple returns.
        for (int k = 0; k < 20; k++) begin
            xa = $urandom; xb = $urandom; xc = $urandom;
            step(xa, xb, xc, 1'b0, 1'b1);
            ya = P; yb = Q; yc = R;
            step(ya, yb, yc, 1'b0, 1'b1);
            check("rev.A", P, xa);
            check("rev.B", Q, xb);
            check("rev.C", R, xc);
        end

        // Long random stream with a reset mid-stream and a clean restart.
        for (int k = 0; k < 1000; k++) begin
            if (k >= 500 && k < 503) begin
                step($urandom, $urandom, $urandom, 1'b1, 1'b0);
                check("mid_rst.P", P, 32'h0000_0000);
                check("mid_rst.Q", Q, 32'h0000_0000);
                check("mid_rst.R", R, 32'h0000_0000);
            end else begin
                step($urandom, $urandom, $urandom, 1'b0, (k % 3) == 0);
                check_out("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
